// File: rtl/exp6_defs_pkg.sv
// Shared definitions for the progressive-sequence game control unit:
// state codes, default replay timing and a small sizing helper.
package exp6_defs;

    localparam logic [3:0] ST_INICIAL          = 4'h0;
    localparam logic [3:0] ST_PREPARACAO       = 4'h1;
    localparam logic [3:0] ST_INICIA_SEQ       = 4'h2;
    localparam logic [3:0] ST_MOSTRA           = 4'h3;
    localparam logic [3:0] ST_INTERVALO_MOSTRA = 4'h4;
    localparam logic [3:0] ST_PROXIMO_MOSTRA   = 4'h5;
    localparam logic [3:0] ST_INICIO_JOGADA    = 4'h6;
    localparam logic [3:0] ST_ESPERA_JOGADA    = 4'h7;
    localparam logic [3:0] ST_REGISTRA         = 4'h8;
    localparam logic [3:0] ST_COMPARACAO       = 4'h9;
    localparam logic [3:0] ST_PROXIMA_JOGADA   = 4'hA;
    localparam logic [3:0] ST_ULTIMA_SEQ       = 4'hB;
    localparam logic [3:0] ST_PROXIMA_SEQ      = 4'hC;
    localparam logic [3:0] ST_FIM_ACERTOU      = 4'hD;
    localparam logic [3:0] ST_FIM_ERROU        = 4'hE;
    localparam logic [3:0] ST_FIM_TIMEOUT      = 4'hF;

    typedef enum logic [3:0] {
        INICIAL          = ST_INICIAL,
        PREPARACAO       = ST_PREPARACAO,
        INICIA_SEQ       = ST_INICIA_SEQ,
        MOSTRA           = ST_MOSTRA,
        INTERVALO_MOSTRA = ST_INTERVALO_MOSTRA,
        PROXIMO_MOSTRA   = ST_PROXIMO_MOSTRA,
        INICIO_JOGADA    = ST_INICIO_JOGADA,
        ESPERA_JOGADA    = ST_ESPERA_JOGADA,
        REGISTRA         = ST_REGISTRA,
        COMPARACAO       = ST_COMPARACAO,
        PROXIMA_JOGADA   = ST_PROXIMA_JOGADA,
        ULTIMA_SEQ       = ST_ULTIMA_SEQ,
        PROXIMA_SEQ      = ST_PROXIMA_SEQ,
        FIM_ACERTOU      = ST_FIM_ACERTOU,
        FIM_ERROU        = ST_FIM_ERROU,
        FIM_TIMEOUT      = ST_FIM_TIMEOUT
    } estado_t;

    localparam int T_MOSTRA_DEFAULT  = 1000;
    localparam int T_APAGADO_DEFAULT = 250;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/unidade_controle_exp6_contador_intervalo.sv
// Interval timer for the LED replay: counts while enabled and flags the last
// cycle of either the lit period or the dark gap, selected by sel_apagado.
module contador_intervalo
    import exp6_defs::*;
#(
    parameter int T_MOSTRA  = T_MOSTRA_DEFAULT,
    parameter int T_APAGADO = T_APAGADO_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic sel_apagado,
    output logic done
);

    localparam int W = $clog2(max_int(T_MOSTRA, T_APAGADO)) + 1;
    localparam logic [W-1:0] FIM_MOSTRA  = W'(T_MOSTRA - 1);
    localparam logic [W-1:0] FIM_APAGADO = W'(T_APAGADO - 1);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    always_comb begin
        done = 1'b0;
        if (enable) begin
            done = (count == (sel_apagado ? FIM_APAGADO : FIM_MOSTRA));
        end
    end

endmodule

// File: rtl/unidade_controle_exp6.sv
// Moore control unit for the progressive-sequence game: replays the first
// limit+1 memory entries, then collects as many timed player moves.
module unidade_controle_exp6
    import exp6_defs::*;
#(
    parameter int T_MOSTRA  = T_MOSTRA_DEFAULT,
    parameter int T_APAGADO = T_APAGADO_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       fimE,
    input  logic       fimL,
    input  logic       enderecoIgualLimite,
    input  logic       jogada,
    input  logic       igual,
    input  logic       timeout,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraT,
    output logic       contaT,
    output logic       mostra_leds,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    estado_t estado;
    estado_t proximo;
    logic    timer_done;
    logic    timer_clear;
    logic    timer_enable;
    logic    unused_fim_e;

    assign unused_fim_e = fimE;

    assign timer_enable = (estado == MOSTRA) || (estado == INTERVALO_MOSTRA);
    assign timer_clear  = (proximo != estado);

    contador_intervalo #(
        .T_MOSTRA  (T_MOSTRA),
        .T_APAGADO (T_APAGADO)
    ) u_intervalo (
        .clock       (clock),
        .reset       (reset),
        .clear       (timer_clear),
        .enable      (timer_enable),
        .sel_apagado (estado == INTERVALO_MOSTRA),
        .done        (timer_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        unique case (estado)
            INICIAL:          if (jogar) proximo = PREPARACAO;
            PREPARACAO:       proximo = INICIA_SEQ;
            INICIA_SEQ:       proximo = MOSTRA;
            MOSTRA:           if (timer_done) proximo = INTERVALO_MOSTRA;
            INTERVALO_MOSTRA: begin
                if (timer_done) begin
                    proximo = enderecoIgualLimite ? INICIO_JOGADA : PROXIMO_MOSTRA;
                end
            end
            PROXIMO_MOSTRA:   proximo = MOSTRA;
            INICIO_JOGADA:    proximo = ESPERA_JOGADA;
            // A move arriving together with the timeout still counts as a move.
            ESPERA_JOGADA: begin
                if (jogada) begin
                    proximo = REGISTRA;
                end else if (timeout) begin
                    proximo = FIM_TIMEOUT;
                end
            end
            REGISTRA:         proximo = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    proximo = FIM_ERROU;
                end else if (enderecoIgualLimite) begin
                    proximo = ULTIMA_SEQ;
                end else begin
                    proximo = PROXIMA_JOGADA;
                end
            end
            PROXIMA_JOGADA:   proximo = ESPERA_JOGADA;
            ULTIMA_SEQ:       proximo = fimL ? FIM_ACERTOU : PROXIMA_SEQ;
            PROXIMA_SEQ:      proximo = INICIA_SEQ;
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
                if (jogar) proximo = PREPARACAO;
            end
            default:          proximo = INICIAL;
        endcase
    end

    always_comb begin
        zeraE       = 1'b0;
        contaE      = 1'b0;
        zeraL       = 1'b0;
        contaL      = 1'b0;
        zeraR       = 1'b0;
        registraR   = 1'b0;
        zeraT       = 1'b0;
        contaT      = 1'b0;
        mostra_leds = 1'b0;
        ganhou      = 1'b0;
        perdeu      = 1'b0;
        pronto      = 1'b0;
        db_timeout  = 1'b0;
        unique case (estado)
            PREPARACAO: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
                zeraT = 1'b1;
            end
            INICIA_SEQ: begin
                zeraE = 1'b1;
                zeraT = 1'b1;
            end
            MOSTRA:         mostra_leds = 1'b1;
            PROXIMO_MOSTRA: contaE = 1'b1;
            INICIO_JOGADA: begin
                zeraE = 1'b1;
                zeraR = 1'b1;
                zeraT = 1'b1;
            end
            ESPERA_JOGADA:  contaT = 1'b1;
            REGISTRA:       registraR = 1'b1;
            PROXIMA_JOGADA: begin
                contaE = 1'b1;
                zeraT  = 1'b1;
            end
            PROXIMA_SEQ:    contaL = 1'b1;
            FIM_ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: doc/unidade_controle_exp6.md
Name: unidade_controle_exp6

Overview:
Moore FSM that sequences the game datapath (fluxo_dados) for the progressive-sequence version of the game. Each round the block replays the first L+1 memory entries on the LEDs, then collects the same number of player moves under a per-move timeout. L grows until the last round (fimL) is completed, or the game ends on the first wrong move or timeout. It replaces the existing control unit in the top level. The datapath interface is unchanged, except for added timeout-timer and LED-display controls.

Parameters:
T_MOSTRA, 1000, clock cycles each sequence element is lit during replay (>=1)
T_APAGADO, 250, clock cycles LEDs stay dark between replayed elements (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 forces state inicial
jogar  in  1  start/restart request (pulse or level)
fimE  in  1  address counter at last position (unused for transitions; debug only)
fimL  in  1  limit counter at last round
enderecoIgualLimite  in  1  address == limit
jogada  in  1  one-cycle pulse: a button move was detected
igual  in  1  registered move == memory data
timeout  in  1  per-move timer expired
zeraE  out  1  clear address counter
contaE  out  1  increment address counter
zeraL  out  1  clear limit counter
contaL  out  1  increment limit counter
zeraR  out  1  clear move register
registraR  out  1  load move register
zeraT  out  1  clear timeout timer
contaT  out  1  enable timeout timer
mostra_leds  out  1  1 = LEDs driven from memory data, 0 = LEDs from buttons/off
ganhou  out  1  game won (held in fim_acertou)
perdeu  out  1  game lost (held in fim_errou / fim_timeout)
pronto  out  1  game finished (any fim state)
db_timeout  out  1  1 only in fim_timeout
db_estado  out  4  current state code

Behaviour:
- Moore outputs decode the current state only. After reset: state inicial (0x0), all outputs 0, interval timer 0.
- States and codes, with asserted outputs and next state:
  - 0 inicial: none. jogar -> 1.
  - 1 preparacao: zeraE, zeraL, zeraR, zeraT. -> 2.
  - 2 inicia_seq: zeraE, zeraT. -> 3.
  - 3 mostra: mostra_leds. Stays T_MOSTRA cycles, then -> 4.
  - 4 intervalo_mostra: none. Stays T_APAGADO cycles. Then enderecoIgualLimite -> 6, else -> 5.
  - 5 proximo_mostra: contaE. -> 3.
  - 6 inicio_jogada: zeraE, zeraR, zeraT. -> 7.
  - 7 espera_jogada: contaT. jogada -> 8; else timeout -> F. If jogada and timeout arrive in the same cycle, jogada wins.
  - 8 registra: registraR. -> 9.
  - 9 comparacao: none. !igual -> E. igual and enderecoIgualLimite -> B. igual and !enderecoIgualLimite -> A.
  - A proxima_jogada: contaE, zeraT. -> 7.
  - B ultima_seq: none. fimL -> D, else -> C.
  - C proxima_seq: contaL. -> 2.
  - D fim_acertou: pronto, ganhou.
  - E fim_errou: pronto, perdeu.
  - F fim_timeout: pronto, perdeu, db_timeout.
  - D/E/F: jogar -> 1, else hold.
- Interval timer:
  - Internal counter, width $clog2(max(T_MOSTRA,T_APAGADO))+1. Cleared on every state change.
  - Counts in states 3 and 4. "done" when count == T-1, where T = T_MOSTRA in state 3 and T_APAGADO in state 4.
  - State 3 therefore lasts exactly T_MOSTRA cycles and state 4 exactly T_APAGADO cycles.
- Round r (limit = r) replays r+1 elements and then accepts r+1 moves. Round 0 replays one element.
- jogar is ignored in every state except 0, D, E, F. Holding jogar high in a fim state restarts once, via 1.
- reset low at any time: immediate return to 0 and outputs cleared, without waiting for a clock edge. Timer cleared.
- No output glitch requirement beyond Moore decode. Datapath samples the outputs on the next rising edge.

Decomposition:
- Shared package/include exp6_defs:
  - 4-bit state code localparams (inicial..fim_timeout, values above).
  - Default T_MOSTRA / T_APAGADO.
- One natural sub-module: contador_intervalo. Parameterized terminal count, with clear/enable inputs and a done output; it implements the interval timer.
- FSM next-state and output decode stay in unidade_controle_exp6.

Test Plan:
- Bench parameters: T_MOSTRA=4, T_APAGADO=2.
- Reset low mid-state 7, then release: db_estado=0x0 asynchronously, all outputs 0; next jogar pulse -> db_estado=1 then 2.
- Round 0 replay (enderecoIgualLimite=1 tied): mostra_leds high exactly 4 cycles, low 2 cycles in state 4, then states 6 -> 7 with contaT=1.
- Correct round 0 with fimL=0: jogada pulse, igual=1 -> states 8, 9, B, C (contaL 1 cycle), 2. Second replay runs 3 -> 4 -> 5 (contaE 1 cycle) -> 3 when enderecoIgualLimite=0.
- Wrong move: state 7, jogada=1, igual=0 -> 8, 9, E. pronto=1, perdeu=1, ganhou=0, held 10 cycles until jogar -> state 1.
- Timeout: state 7 with timeout=1, jogada=0 -> F, db_timeout=1, perdeu=1. Repeat with timeout=1 and jogada=1 in the same cycle -> state 8, not F.
- Win: last round with fimL=1, all moves igual=1 -> B -> D. ganhou=1, pronto=1, db_estado=0xD, stable until jogar.
